// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared constants and types for the UART transmitter.
//   - parity mode codes (the PARITY parameter takes one of these)
//   - standard baud divisors for a 50 MHz clock
//   - transmitter FSM state encoding
package uart_tx_pkg;

  localparam int UART_PARITY_NONE = 0;
  localparam int UART_PARITY_EVEN = 1;
  localparam int UART_PARITY_ODD  = 2;

  localparam int UART_CLKS_PER_BIT_115200 = 434;
  localparam int UART_CLKS_PER_BIT_921600 = 54;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready word stream feeding the UART transmitter.
//   in_valid : producer has a word on in_data
//   in_data  : word to transmit, LSB first on the line
//   in_ready : transmitter accepts a word this cycle
// master = producer side, slave = transmitter side.
interface uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-time counter shared by the UART transmitter/receiver.
//   clk, rst   : clock, synchronous active-high reset
//   en         : count this cycle (0..CLKS_PER_BIT-1, wrapping)
//   clr        : force the count to 0 (has priority over en)
//   tick       : high in the terminal-count cycle of each bit
//   tick_early : high in the cycle before the terminal count, so callers can
//                produce registered outputs aligned with the terminal cycle
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic tick_early
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERM  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] EARLY = CW'(CLKS_PER_BIT - 2);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_baud_tick: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  logic [CW-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = (cnt_reg == TERM) ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_reg <= '0;
    else     cnt_reg <= cnt_next;
  end

  assign tick       = en && !clr && (cnt_reg == TERM);
  assign tick_early = en && !clr && (cnt_reg == EARLY);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-word holding buffer.
//   clk, rst : clock, synchronous active-high reset
//   in_if    : valid/ready word stream (slave side); in_ready = !buf_full
//   txd      : serial line, idles at 1 (registered)
//   busy     : a frame is on the line (registered)
//   tx_done  : pulse in the final cycle of the last stop bit (registered)
// Frame: start(0), DATA_W bits LSB first, optional parity, STOP_BITS stop(1).
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 54,
  parameter int DATA_W       = 8,
  parameter int PARITY       = UART_PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_if.slave     in_if,
  output logic         txd,
  output logic         busy,
  output logic         tx_done
);

  generate
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_dw
      $error("uart_tx: DATA_W must be 5..9");
    end
    if (PARITY < UART_PARITY_NONE || PARITY > UART_PARITY_ODD) begin : g_bad_par
      $error("uart_tx: PARITY must be NONE, EVEN or ODD");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam int            BW         = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_W - 1);
  localparam logic          LAST_STOP  = (STOP_BITS == 2);
  localparam bit            HAS_PARITY = (PARITY != UART_PARITY_NONE);
  localparam logic          ODD_PAR    = (PARITY == UART_PARITY_ODD);

  uart_tx_state_t    state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] buf_reg, buf_next;
  logic              buf_full_reg, buf_full_next;
  logic              parity_reg, parity_next;
  logic [BW-1:0]     bit_reg, bit_next;
  logic              stop_reg, stop_next;
  logic              txd_reg, txd_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic              tick, tick_early;
  logic              xfer;
  logic              load;
  logic              load_from_buf;
  logic [DATA_W-1:0] load_word;

  // The counter is held at 0 while idle, so a new frame's first bit is
  // exactly CLKS_PER_BIT cycles; between back-to-back frames it just wraps.
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .rst        (rst),
    .en         (state_reg != ST_IDLE),
    .clr        (state_reg == ST_IDLE),
    .tick       (tick),
    .tick_early (tick_early)
  );

  assign in_if.in_ready = !buf_full_reg;
  assign xfer           = in_if.in_valid && !buf_full_reg;

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    buf_next      = buf_reg;
    buf_full_next = buf_full_reg;
    parity_next   = parity_reg;
    bit_next      = bit_reg;
    stop_next     = stop_reg;
    txd_next      = txd_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    load          = 1'b0;
    load_from_buf = 1'b0;
    load_word     = in_if.in_data;

    case (state_reg)
      ST_IDLE: begin
        if (xfer) load = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          state_next = ST_DATA;
          txd_next   = shift_reg[0];
          bit_next   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_reg == LAST_BIT) begin
            if (HAS_PARITY) begin
              state_next = ST_PARITY;
              txd_next   = parity_reg;
            end else begin
              state_next = ST_STOP;
              txd_next   = 1'b1;
              stop_next  = 1'b0;
            end
          end else begin
            // Bit on the line next is shift_reg[1]; shift so it lands at [0].
            bit_next   = bit_reg + 1'b1;
            txd_next   = shift_reg[1];
            shift_next = {1'b0, shift_reg[DATA_W-1:1]};
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_next = ST_STOP;
          txd_next   = 1'b1;
          stop_next  = 1'b0;
        end
      end
      ST_STOP: begin
        done_next = (stop_reg == LAST_STOP) && tick_early;
        if (tick) begin
          if (stop_reg == LAST_STOP) begin
            if (buf_full_reg) begin
              load          = 1'b1;
              load_from_buf = 1'b1;
              load_word     = buf_reg;
              buf_full_next = 1'b0;
            end else if (xfer) begin
              load = 1'b1;
            end else begin
              state_next = ST_IDLE;
              busy_next  = 1'b0;
              txd_next   = 1'b1;
            end
          end else begin
            stop_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        txd_next   = 1'b1;
        busy_next  = 1'b0;
      end
    endcase

    if (load) begin
      state_next  = ST_START;
      shift_next  = load_word;
      parity_next = (^load_word) ^ ODD_PAR;
      txd_next    = 1'b0;
      busy_next   = 1'b1;
    end

    // A word accepted while a frame is running (and not taken straight
    // into the shift register) waits in the holding buffer.
    if (xfer && !(load && !load_from_buf)) begin
      buf_next      = in_if.in_data;
      buf_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      buf_reg      <= '0;
      buf_full_reg <= 1'b0;
      parity_reg   <= 1'b0;
      bit_reg      <= '0;
      stop_reg     <= 1'b0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      buf_reg      <= buf_next;
      buf_full_reg <= buf_full_next;
      parity_reg   <= parity_next;
      bit_reg      <= bit_next;
      stop_reg     <= stop_next;
      txd_reg      <= txd_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign txd     = txd_reg;
  assign busy    = busy_reg;
  assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Five instances cover the configurations of interest; 'sel' picks which one
// is driven and observed. Accepted words go into a scoreboard queue; frames
// are rebuilt from a per-cycle history of the line and compared against a
// frame model built from the popped word.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int HMAX = 4096;

  typedef struct {
    int cpb;
    int dw;
    int par;
    int sb;
  } cfg_t;

  typedef struct {
    logic [8:0] data;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   sel = 0;
  logic drv_valid = 1'b0;
  logic [8:0] drv_data = '0;

  int tests  = 0;
  int errors = 0;

  cfg_t cfgs[5];
  exp_t sb_q[$];

  logic hist_txd  [HMAX];
  logic hist_busy [HMAX];
  logic hist_done [HMAX];
  logic hist_ready[HMAX];

  wire [4:0] txd_v, busy_v, done_v, ready_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_if #(.DATA_W(8)) if0 ();
  uart_tx_if #(.DATA_W(8)) if1 ();
  uart_tx_if #(.DATA_W(8)) if2 ();
  uart_tx_if #(.DATA_W(8)) if3 ();
  uart_tx_if #(.DATA_W(5)) if4 ();

  assign if0.in_valid = drv_valid && (sel == 0);
  assign if1.in_valid = drv_valid && (sel == 1);
  assign if2.in_valid = drv_valid && (sel == 2);
  assign if3.in_valid = drv_valid && (sel == 3);
  assign if4.in_valid = drv_valid && (sel == 4);
  assign if0.in_data  = drv_data[7:0];
  assign if1.in_data  = drv_data[7:0];
  assign if2.in_data  = drv_data[7:0];
  assign if3.in_data  = drv_data[7:0];
  assign if4.in_data  = drv_data[4:0];
  assign ready_v = {if4.in_ready, if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};

  uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(UART_PARITY_NONE), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .in_if(if0), .txd(txd_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(UART_PARITY_EVEN), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .in_if(if1), .txd(txd_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(UART_PARITY_ODD), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .in_if(if2), .txd(txd_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY(UART_PARITY_NONE), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .in_if(if3), .txd(txd_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));
  uart_tx #(.CLKS_PER_BIT(2), .DATA_W(5), .PARITY(UART_PARITY_ODD), .STOP_BITS(1)) u4 (
    .clk(clk), .rst(rst), .in_if(if4), .txd(txd_v[4]), .busy(busy_v[4]), .tx_done(done_v[4]));

  // Per-cycle history of the selected instance, indexed by cycle number.
  always @(negedge clk) begin
    if (cyc < HMAX) begin
      hist_txd[cyc]   <= txd_v[sel];
      hist_busy[cyc]  <= busy_v[sel];
      hist_done[cyc]  <= done_v[sel];
      hist_ready[cyc] <= ready_v[sel];
    end
  end

  // Expected line level per cycle for one frame (bit i = cycle load+1+i).
  function automatic logic [63:0] exp_line(input cfg_t c, input logic [8:0] d, output int n);
    logic [15:0] bits;
    logic [63:0] line;
    logic        p;
    int          nb;
    bits = '0;
    line = '0;
    p    = 1'b0;
    nb   = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < c.dw; i++) begin
      bits[nb] = d[i]; nb++;
      p = p ^ d[i];
    end
    if (c.par != UART_PARITY_NONE) begin
      bits[nb] = (c.par == UART_PARITY_ODD) ? ~p : p; nb++;
    end
    for (int i = 0; i < c.sb; i++) begin
      bits[nb] = 1'b1; nb++;
    end
    n = nb * c.cpb;
    for (int j = 0; j < n; j++) line[j] = bits[j / c.cpb];
    return line;
  endfunction

  // Offer a word at the current falling edge; records the accept cycle.
  task automatic drive_word(input logic [8:0] d, input bit keep, output int acc);
    int   budget;
    exp_t e;
    budget    = 400;
    acc       = -1;
    drv_data  = d;
    drv_valid = 1'b1;
    while (budget > 0) begin
      if (ready_v[sel] === 1'b1) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
      budget--;
    end
    if (acc < 0) begin
      tests++; errors++;
      $display("FAIL accept_timeout: data=%h got no in_ready, required in_ready=1", d);
      drv_valid = 1'b0;
      return;
    end
    e.data = d;
    e.acc  = acc;
    sb_q.push_back(e);
    $display("[TB] accept inst=%0d data=%h cycle=%0d", sel, d, acc);
    @(negedge clk);
    if (!keep) drv_valid = 1'b0;
  endtask

  // Check 'count' chained frames on the selected instance.
  task automatic check_frames(input int count, input string name);
    int          load, n, budget;
    exp_t        e;
    logic [63:0] exp_l, obs_l, exp_d, obs_d;
    logic        all_busy;
    budget = 400;
    while (sb_q.size() == 0 && budget > 0) begin
      @(negedge clk); budget--;
    end
    if (sb_q.size() == 0) begin
      tests++; errors++;
      $display("FAIL %s_scoreboard: got 0 accepted words, required >= 1", name);
      return;
    end
    load = sb_q[0].acc;
    for (int k = 0; k < count; k++) begin
      void'(exp_line(cfgs[sel], 9'h0, n));
      budget = 600;
      while ((cyc <= load + n || sb_q.size() == 0) && budget > 0) begin
        @(negedge clk); budget--;
      end
      if (budget == 0) begin
        tests++; errors++;
        $display("FAIL %s_frame_timeout: frame %0d never completed (queue=%0d)", name, k, sb_q.size());
        return;
      end
      e        = sb_q.pop_front();
      exp_l    = exp_line(cfgs[sel], e.data, n);
      exp_d    = 64'd1 << (n - 1);
      obs_l    = '0;
      obs_d    = '0;
      all_busy = 1'b1;
      for (int i = 0; i < n; i++) begin
        obs_l[i] = hist_txd[load + 1 + i];
        obs_d[i] = hist_done[load + 1 + i];
        all_busy = all_busy & hist_busy[load + 1 + i];
      end
      $display("[TB] frame %s inst=%0d data=%h load=%0d len=%0d", name, sel, e.data, load, n);
      tests++;
      if (obs_l !== exp_l) begin
        errors++;
        $display("FAIL %s_txd: data=%h line=%h required %h", name, e.data, obs_l, exp_l);
      end
      tests++;
      if (obs_d !== exp_d) begin
        errors++;
        $display("FAIL %s_tx_done: data=%h pulses=%h required %h", name, e.data, obs_d, exp_d);
      end
      tests++;
      if (all_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy: data=%h busy dropped in frame, required continuous 1", name, e.data);
      end
      tests++;
      if (e.acc > load) begin
        errors++;
        $display("FAIL %s_order: data=%h accepted at %0d, after its frame load %0d", name, e.data, e.acc, load);
      end
      load = load + n;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    drv_data  = 9'h0AA;
    drv_valid = 1'b1;          // offered while in reset: must be ignored
    @(negedge clk);
    rst       = 1'b0;
    drv_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      tests++;
      if ({txd_v[k], busy_v[k], done_v[k], ready_v[k]} !== 4'b1001) begin
        errors++;
        $display("FAIL reset_state inst=%0d: txd/busy/done/ready=%b required 1001", k,
                 {txd_v[k], busy_v[k], done_v[k], ready_v[k]});
      end
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    int acc;
    sel = 0;
    drive_word(9'h055, 1'b0, acc);
    check_frames(1, "basic");
    tests++;
    if (hist_txd[acc + 1] !== 1'b0 || hist_busy[acc] !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: txd@t+1=%b busy@t=%b required 0 0", hist_txd[acc + 1], hist_busy[acc]);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (hist_busy[acc + 41] !== 1'b0 || hist_txd[acc + 41] !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle_after: busy=%b txd=%b required 0 1", hist_busy[acc + 41], hist_txd[acc + 41]);
    end
  endtask

  task automatic test_parity();
    int acc;
    sel = 1;
    drive_word(9'h007, 1'b0, acc);
    check_frames(1, "even");
    tests++;
    if (hist_txd[acc + 37] !== 1'b1 || hist_txd[acc + 40] !== 1'b1) begin
      errors++;
      $display("FAIL even_parity_bit: got %b%b required 11", hist_txd[acc + 37], hist_txd[acc + 40]);
    end
    sel = 2;
    repeat (2) @(negedge clk);
    drive_word(9'h007, 1'b0, acc);
    check_frames(1, "odd");
    tests++;
    if (hist_txd[acc + 37] !== 1'b0 || hist_txd[acc + 40] !== 1'b0 || hist_done[acc + 44] !== 1'b1) begin
      errors++;
      $display("FAIL odd_parity_bit: parity=%b%b done@44=%b required 00 1",
               hist_txd[acc + 37], hist_txd[acc + 40], hist_done[acc + 44]);
    end
  endtask

  task automatic test_two_stop();
    int acc;
    sel = 3;
    repeat (2) @(negedge clk);
    drive_word(9'h0A3, 1'b0, acc);
    check_frames(1, "two_stop");
    tests++;
    if (hist_done[acc + 44] !== 1'b1 || hist_done[acc + 40] !== 1'b0 || hist_txd[acc + 37] !== 1'b1) begin
      errors++;
      $display("FAIL two_stop_done: done@40=%b done@44=%b stop@37=%b required 0 1 1",
               hist_done[acc + 40], hist_done[acc + 44], hist_txd[acc + 37]);
    end
  endtask

  task automatic test_back_to_back();
    int acc0, acc1, acc2;
    sel = 0;
    repeat (2) @(negedge clk);
    fork
      begin
        drive_word(9'h012, 1'b1, acc0);
        drive_word(9'h034, 1'b1, acc1);
        drive_word(9'h056, 1'b0, acc2);
      end
      check_frames(3, "b2b");
    join
    tests++;
    if (acc1 - acc0 !== 1 || acc2 - acc0 !== 41) begin
      errors++;
      $display("FAIL b2b_accept: offsets %0d %0d required 1 41", acc1 - acc0, acc2 - acc0);
    end
    tests++;
    if (hist_ready[acc0 + 2] !== 1'b0 || hist_ready[acc0 + 40] !== 1'b0 || hist_ready[acc0 + 42] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready: ready@t+2=%b @t+40=%b @t+42=%b required 0 0 0",
               hist_ready[acc0 + 2], hist_ready[acc0 + 40], hist_ready[acc0 + 42]);
    end
    tests++;
    if (hist_txd[acc0 + 41] !== 1'b0 || hist_busy[acc0 + 41] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: txd@t+41=%b busy=%b required 0 1", hist_txd[acc0 + 41], hist_busy[acc0 + 41]);
    end
  endtask

  task automatic test_reset_mid();
    int  acc0, acc1, budget, t_rst;
    logic any_done, any_low;
    sel = 0;
    repeat (4) @(negedge clk);
    drive_word(9'h03C, 1'b0, acc0);
    drive_word(9'h099, 1'b0, acc1);
    budget = 100;
    while (cyc < acc0 + 18 && budget > 0) begin
      @(negedge clk); budget--;
    end
    rst   = 1'b1;          // mid data bit 3
    t_rst = cyc;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({txd_v[0], busy_v[0], done_v[0], ready_v[0]} !== 4'b1001) begin
      errors++;
      $display("FAIL midreset_state: txd/busy/done/ready=%b required 1001",
               {txd_v[0], busy_v[0], done_v[0], ready_v[0]});
    end
    repeat (50) @(negedge clk);
    any_done = 1'b0;
    any_low  = 1'b0;
    for (int c = t_rst + 1; c < cyc; c++) begin
      any_done = any_done | hist_done[c];
      any_low  = any_low | ~hist_txd[c];
    end
    tests++;
    if (any_done !== 1'b0 || any_low !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet: tx_done seen=%b txd low seen=%b required 0 0", any_done, any_low);
    end
    sb_q.delete();
    $display("[TB] reset mid-frame at cycle %0d, scoreboard flushed", t_rst);
    drive_word(9'h00F, 1'b0, acc0);
    check_frames(1, "after_reset");
  endtask

  task automatic test_min();
    int acc;
    sel = 4;
    repeat (2) @(negedge clk);
    drive_word(9'h01F, 1'b0, acc);
    check_frames(1, "min");
    tests++;
    if (hist_txd[acc + 13] !== 1'b0 || hist_txd[acc + 14] !== 1'b0 ||
        hist_done[acc + 16] !== 1'b1 || hist_txd[acc + 15] !== 1'b1) begin
      errors++;
      $display("FAIL min_frame: parity=%b%b stop=%b done@16=%b required 00 1 1",
               hist_txd[acc + 13], hist_txd[acc + 14], hist_txd[acc + 15], hist_done[acc + 16]);
    end
  endtask

  initial begin
    cfgs[0] = '{cpb: 4, dw: 8, par: UART_PARITY_NONE, sb: 1};
    cfgs[1] = '{cpb: 4, dw: 8, par: UART_PARITY_EVEN, sb: 1};
    cfgs[2] = '{cpb: 4, dw: 8, par: UART_PARITY_ODD,  sb: 1};
    cfgs[3] = '{cpb: 4, dw: 8, par: UART_PARITY_NONE, sb: 2};
    cfgs[4] = '{cpb: 2, dw: 5, par: UART_PARITY_ODD,  sb: 1};
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid();
    test_min();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
